approx_adder_error_monitor: RTL and testbench
=============================================

# approx_adder_error_monitor

Sequential error-characterisation block for the approximate parallel-prefix adders. It consumes a stream of operand pairs together with the sum produced by an approximate adder under test. It recomputes the exact sum and accumulates error metrics over a fixed window of samples: error count, sum of error distances and maximum error distance. It sits at the output of any WIDTH-bit approximate adder in the characterisation testbench or on-chip BIST wrapper, and reports results with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand width; sum inputs are WIDTH+1 bits
- WINDOW, 256, samples accepted per measurement (1 .. 2^ACC_W-1)
- ACC_W, 24, width of count and accumulator outputs
- clk  input  1  rising-edge clock (the block's one clock)
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a measurement window; sampled only in IDLE
- in_valid  input  1  operand/sum sample present
- in_ready  output  1  block accepts a sample this cycle
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- approx_sum  input  WIDTH+1  sum from the adder under test, carry in MSB
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse, results final
- sample_count  output  ACC_W  samples accepted in the current/last window
- err_count  output  ACC_W  samples with approx_sum != op_a+op_b
- sed  output  ACC_W  saturating sum of error distances
- max_ed  output  WIDTH+1  largest error distance seen

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. start=1 -> clear sample_count, err_count, sed, max_ed; go to RUN.
- RUN: in_ready=1 while the accepted count is below WINDOW. A sample is accepted when in_valid & in_ready. On acceptance of sample number WINDOW, go to DRAIN; in_ready=0 from the next cycle.
- DRAIN: one cycle; the last sample finishes its pipeline. Then DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Outputs are held until the next start.
- Sample handling is pipelined in two stages:
  - S1 registers the exact sum op_a+op_b (WIDTH+1 bits, no overflow) and ED = |exact - approx_sum| (WIDTH+1 bits, unsigned).
  - S2 updates the outputs: sample_count+1; err_count+1 if ED!=0; sed+=ED, saturating at 2^ACC_W-1; max_ed=max(max_ed, ED).
- start is ignored outside IDLE. in_valid is ignored when in_ready=0, and the data is not consumed.
- rst_n low at any time, including mid-window: state IDLE and all pipeline registers cleared immediately. The partial window is discarded.
- Reset values: in_ready=0, busy=0, done=0, sample_count=0, err_count=0, sed=0, max_ed=0.

## Timing
- start high in IDLE in cycle T -> busy=1 and in_ready=1 in cycle T+1. Accumulators read 0 in T+1.
- Sample accepted in cycle C -> reflected in the outputs in cycle C+2. Back-to-back acceptance is supported at one sample per cycle.
- Last (WINDOW-th) acceptance in cycle L:
  - in_ready=0 from L+1 (DRAIN).
  - done=1 and final results in L+2 (DONE).
  - busy=0 from L+3.
- Outputs change only on S2 updates and on start-clear. No combinational path from inputs to outputs except in_ready, which depends on state only.

## Test plan
- Reset: hold rst_n=0, toggle clk and inputs -> all outputs 0, in_ready=0. Release, no start -> in_ready stays 0 with in_valid=1.
- WINDOW=4, four exact samples (3,5,8) back-to-back -> done exactly 2 cycles after the 4th accept; sample_count=4, err_count=0, sed=0, max_ed=0.
- WINDOW=4, samples in order:
  - (200,100,300): ED 0
  - (255,255,254): ED 256
  - (1,1,3): ED 1
  - (0,0,0): ED 0
  - Required -> err_count=2, sed=257, max_ed=256, sample_count=4.
- Flow control, WINDOW=4: in_valid toggled 1,0,1,1,0,1,1 and start pulsed during RUN -> exactly 4 samples accepted. in_ready=0 after the 4th accept. The 5th valid is not consumed. start has no effect.
- Saturation, ACC_W=8, WINDOW=2: samples (255,255,310) ED 200, then (0,0,200) ED 200 -> sed=255, err_count=2, max_ed=200.
- Mid-window reset, WINDOW=4: drop rst_n after 2 erroneous samples -> all outputs 0 asynchronously. After release, no samples are accepted until start. A new window then counts from 0.

Source files
------------

// File: rtl/approx_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : approx_adder_error_monitor
// Description : Windowed error characterisation for an approximate adder.
//               Recomputes the exact sum of each accepted operand pair and
//               accumulates error count, saturating sum of error distances
//               and maximum error distance over WINDOW samples.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_adder_error_monitor #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 256,
    parameter int ACC_W  = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH:0]   approx_sum,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sample_count,
    output logic [ACC_W-1:0] err_count,
    output logic [ACC_W-1:0] sed,
    output logic [WIDTH:0]   max_ed
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    // One extra bit beyond the wider of accumulator and distance catches overflow.
    localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

    localparam logic [ACC_W-1:0] c_last = ACC_W'(WINDOW - 1);
    localparam logic [SUM_W-1:0] c_sat  = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_start_clr;
    logic [ACC_W-1:0] r_acc_cnt;
    logic [WIDTH:0]   w_exact;
    logic [WIDTH:0]   w_ed;
    logic             r_s1_valid;
    logic [WIDTH:0]   r_s1_ed;
    logic [SUM_W-1:0] w_sed_sum;
    logic [ACC_W-1:0] r_sample_count;
    logic [ACC_W-1:0] r_err_count;
    logic [ACC_W-1:0] r_sed;
    logic [WIDTH:0]   r_max_ed;

    // Readiness depends on state only, so no input reaches an output combinationally.
    assign w_in_ready  = (r_state == c_run);
    assign w_accept    = in_valid & w_in_ready;
    assign w_start_clr = (r_state == c_idle) & start;

    assign w_exact = {1'b0, op_a} + {1'b0, op_b};
    assign w_ed    = (w_exact >= approx_sum) ? (w_exact - approx_sum) : (approx_sum - w_exact);

    assign w_sed_sum = {{(SUM_W - ACC_W){1'b0}}, r_sed}
                     + {{(SUM_W - WIDTH - 1){1'b0}}, r_s1_ed};

    assign in_ready     = w_in_ready;
    assign busy         = (r_state != c_idle);
    assign done         = (r_state == c_done);
    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;
    assign sed          = r_sed;
    assign max_ed       = r_max_ed;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: RUN ends on the WINDOW-th acceptance, DRAIN lets S2 finish.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (start) w_next_state = c_run;
            c_run:   if (w_accept && (r_acc_cnt == c_last)) w_next_state = c_drain;
            c_drain: w_next_state = c_done;
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Acceptance counter, independent of the lagging sample_count output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
        end else if (w_start_clr) begin
            r_acc_cnt <= '0;
        end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + 1'b1;
        end
    end

    // Stage 1: capture the error distance of the accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ed    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ed <= w_ed;
            end
        end
    end

    // Stage 2: fold the distance into the metrics; start clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_sed          <= '0;
            r_max_ed       <= '0;
        end else if (w_start_clr) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_sed          <= '0;
            r_max_ed       <= '0;
        end else if (r_s1_valid) begin
            r_sample_count <= r_sample_count + 1'b1;
            if (r_s1_ed != '0) begin
                r_err_count <= r_err_count + 1'b1;
            end
            r_sed <= (w_sed_sum > c_sat) ? {ACC_W{1'b1}} : w_sed_sum[ACC_W-1:0];
            if (r_s1_ed > r_max_ed) begin
                r_max_ed <= r_s1_ed;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_adder_error_monitor
// Description : Directed, table-driven bench for approx_adder_error_monitor.
//               One instance with WINDOW=4/ACC_W=24, one with WINDOW=2/ACC_W=8
//               for accumulator saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_adder_error_monitor;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] s;
        int         cnt;
        int         err;
        int         sed;
        int         mx;
    } vec_t;

    logic clk;
    logic rst_n;

    logic        a_start, a_in_valid, a_in_ready, a_busy, a_done;
    logic [7:0]  a_op_a, a_op_b;
    logic [8:0]  a_approx, a_max;
    logic [23:0] a_cnt, a_err, a_sed;

    logic        s_start, s_in_valid, s_in_ready, s_busy, s_done;
    logic [7:0]  s_op_a, s_op_b;
    logic [8:0]  s_approx, s_max;
    logic [7:0]  s_cnt, s_err, s_sed;

    int   n_chk;
    int   n_err;
    vec_t vecs [17];

    approx_adder_error_monitor #(.WIDTH(8), .WINDOW(4), .ACC_W(24)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .op_a(a_op_a), .op_b(a_op_b), .approx_sum(a_approx),
        .busy(a_busy), .done(a_done), .sample_count(a_cnt), .err_count(a_err),
        .sed(a_sed), .max_ed(a_max)
    );

    approx_adder_error_monitor #(.WIDTH(8), .WINDOW(2), .ACC_W(8)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .op_a(s_op_a), .op_b(s_op_b), .approx_sum(s_approx),
        .busy(s_busy), .done(s_done), .sample_count(s_cnt), .err_count(s_err),
        .sed(s_sed), .max_ed(s_max)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_a_metrics(input string tag, input int cnt, input int err,
                                 input int sd, input int mx);
        chk({tag, "_cnt"}, int'(a_cnt), cnt);
        chk({tag, "_err"}, int'(a_err), err);
        chk({tag, "_sed"}, int'(a_sed), sd);
        chk({tag, "_max"}, int'(a_max), mx);
    endtask

    // Full WINDOW=4 run on instance A, back-to-back, from vecs[base..base+3].
    task automatic run_window_a(input int base, input string tag);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk({tag, "_busy_T1"}, int'(a_busy), 1);
        chk({tag, "_ready_T1"}, int'(a_in_ready), 1);
        chk_a_metrics({tag, "_clr"}, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_op_a     = vecs[base + i].a;
            a_op_b     = vecs[base + i].b;
            a_approx   = vecs[base + i].s;
            chk({tag, "_ready_run"}, int'(a_in_ready), 1);
            tick();
            if (i > 0) begin
                chk_a_metrics({tag, "_pipe"}, vecs[base + i - 1].cnt, vecs[base + i - 1].err,
                              vecs[base + i - 1].sed, vecs[base + i - 1].mx);
            end
        end
        chk({tag, "_ready_L1"}, int'(a_in_ready), 0);
        chk({tag, "_done_L1"}, int'(a_done), 0);
        chk({tag, "_busy_L1"}, int'(a_busy), 1);
        a_in_valid = 1'b0;
        tick();
        chk({tag, "_done_L2"}, int'(a_done), 1);
        chk_a_metrics({tag, "_final"}, vecs[base + 3].cnt, vecs[base + 3].err,
                      vecs[base + 3].sed, vecs[base + 3].mx);
        tick();
        chk({tag, "_done_L3"}, int'(a_done), 0);
        chk({tag, "_busy_L3"}, int'(a_busy), 0);
        chk_a_metrics({tag, "_hold"}, vecs[base + 3].cnt, vecs[base + 3].err,
                      vecs[base + 3].sed, vecs[base + 3].mx);
    endtask

    initial begin
        bit [6:0] pat_v;
        bit [6:0] pat_r;
        int       j;

        n_chk = 0;
        n_err = 0;

        // Window 1: exact samples.
        vecs[0]  = '{8'd3,   8'd5,   9'd8,   1, 0, 0,   0};
        vecs[1]  = '{8'd3,   8'd5,   9'd8,   2, 0, 0,   0};
        vecs[2]  = '{8'd3,   8'd5,   9'd8,   3, 0, 0,   0};
        vecs[3]  = '{8'd3,   8'd5,   9'd8,   4, 0, 0,   0};
        // Window 2: mixed errors (ED 0, 256, 1, 0).
        vecs[4]  = '{8'd200, 8'd100, 9'd300, 1, 0, 0,   0};
        vecs[5]  = '{8'd255, 8'd255, 9'd254, 2, 1, 256, 256};
        vecs[6]  = '{8'd1,   8'd1,   9'd3,   3, 2, 257, 256};
        vecs[7]  = '{8'd0,   8'd0,   9'd0,   4, 2, 257, 256};
        // Window after mid-window reset (ED 1, 0, 0, 0).
        vecs[8]  = '{8'd2,   8'd2,   9'd5,   1, 1, 1,   1};
        vecs[9]  = '{8'd7,   8'd9,   9'd16,  2, 1, 1,   1};
        vecs[10] = '{8'd7,   8'd9,   9'd16,  3, 1, 1,   1};
        vecs[11] = '{8'd7,   8'd9,   9'd16,  4, 1, 1,   1};
        // Flow-control samples (ED 1, 2, 3, 4, then 100 which must not be taken).
        vecs[12] = '{8'd10,  8'd1,   9'd12,  0, 0, 0,   0};
        vecs[13] = '{8'd20,  8'd2,   9'd24,  0, 0, 0,   0};
        vecs[14] = '{8'd30,  8'd3,   9'd36,  0, 0, 0,   0};
        vecs[15] = '{8'd40,  8'd4,   9'd48,  0, 0, 0,   0};
        vecs[16] = '{8'd50,  8'd5,   9'd155, 0, 0, 0,   0};

        rst_n      = 1'b0;
        a_start    = 1'b0;
        a_in_valid = 1'b0;
        a_op_a     = '0;
        a_op_b     = '0;
        a_approx   = '0;
        s_start    = 1'b0;
        s_in_valid = 1'b0;
        s_op_a     = '0;
        s_op_b     = '0;
        s_approx   = '0;

        // Reset held while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            a_start    = ~a_start;
            a_in_valid = ~a_in_valid;
            a_op_a     = 8'(i * 37);
            a_approx   = 9'(i * 91);
            tick();
            chk("rst_ready", int'(a_in_ready), 0);
            chk("rst_busy", int'(a_busy), 0);
            chk("rst_done", int'(a_done), 0);
            chk_a_metrics("rst", 0, 0, 0, 0);
        end
        a_start    = 1'b0;
        a_in_valid = 1'b1;
        rst_n      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_ready", int'(a_in_ready), 0);
            chk("idle_busy", int'(a_busy), 0);
        end
        a_in_valid = 1'b0;

        run_window_a(0, "exact");
        run_window_a(4, "mixed");

        // Flow control: gaps in in_valid, a stray start, and a fifth sample offered.
        pat_v = 7'b1101101;
        pat_r = 7'b0111111;
        j     = 12;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            a_in_valid = pat_v[k];
            a_start    = (k == 2);
            a_op_a     = vecs[j].a;
            a_op_b     = vecs[j].b;
            a_approx   = vecs[j].s;
            chk("flow_ready", int'(a_in_ready), int'(pat_r[k]));
            tick();
            if (pat_v[k] && pat_r[k]) j++;
        end
        a_in_valid = 1'b0;
        a_start    = 1'b0;
        chk("flow_done", int'(a_done), 1);
        chk_a_metrics("flow", 4, 4, 10, 4);
        tick();
        chk("flow_busy_end", int'(a_busy), 0);
        chk_a_metrics("flow_hold", 4, 4, 10, 4);

        // Saturation on the narrow-accumulator instance.
        s_start = 1'b1;
        tick();
        s_start    = 1'b0;
        s_in_valid = 1'b1;
        s_op_a     = 8'd255;
        s_op_b     = 8'd255;
        s_approx   = 9'd310;
        tick();
        s_op_a   = 8'd0;
        s_op_b   = 8'd0;
        s_approx = 9'd200;
        tick();
        chk("sat_sed_first", int'(s_sed), 200);
        s_in_valid = 1'b0;
        tick();
        chk("sat_done", int'(s_done), 1);
        chk("sat_sed", int'(s_sed), 255);
        chk("sat_err", int'(s_err), 2);
        chk("sat_max", int'(s_max), 200);
        chk("sat_cnt", int'(s_cnt), 2);

        // Mid-window asynchronous reset.
        a_start = 1'b1;
        tick();
        a_start    = 1'b0;
        a_in_valid = 1'b1;
        a_op_a     = 8'd1;
        a_op_b     = 8'd1;
        a_approx   = 9'd3;
        tick();
        a_op_a   = 8'd255;
        a_op_b   = 8'd255;
        a_approx = 9'd254;
        tick();
        a_in_valid = 1'b0;
        tick();
        chk_a_metrics("mid_pre", 2, 2, 257, 256);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(a_busy), 0);
        chk("mid_rst_ready", int'(a_in_ready), 0);
        chk_a_metrics("mid_rst", 0, 0, 0, 0);
        tick();
        rst_n      = 1'b1;
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_idle_ready", int'(a_in_ready), 0);
            chk("mid_idle_cnt", int'(a_cnt), 0);
        end
        a_in_valid = 1'b0;
        run_window_a(8, "post");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
